// File: rtl/vx_dot8_pe_if.sv
// vx_dot8_pe_if: operand/result handshake bundle for the dot8 PE.
// master = upstream producer and result consumer, slave = the PE.
interface vx_dot8_pe_if #(
    parameter int TAG_WIDTH = 1
);
    logic                 valid_in;
    logic                 ready_in;
    logic [31:0]          a_in;
    logic [31:0]          b_in;
    logic [TAG_WIDTH-1:0] tag_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [31:0]          data_out;
    logic [TAG_WIDTH-1:0] tag_out;

    modport master (
        output valid_in, a_in, b_in, tag_in, ready_out,
        input  ready_in, valid_out, data_out, tag_out
    );

    modport slave (
        input  valid_in, a_in, b_in, tag_in, ready_out,
        output ready_in, valid_out, data_out, tag_out
    );
endinterface

// File: rtl/vx_dot8_pe.sv
// vx_dot8_pe: signed 4x int8 dot product, elastic 2-stage valid/ready pipe.
// Define DOT8_SAT_EN to clamp results to int16 and expose sticky sat_flag.
module vx_dot8_pe #(
    parameter int TAG_WIDTH = 1,
    parameter bit OUT_REG   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DOT8_SAT_EN
    output logic        sat_flag,
`endif
    vx_dot8_pe_if.slave bus
);
    logic                 s1_valid_q;
    logic [TAG_WIDTH-1:0] s1_tag_q;
    logic [15:0]          p_q [4];
    logic [15:0]          p_d [4];
    logic                 s1_go;
    logic                 s1_adv;
    logic                 accept;
    logic signed [17:0]   sum;
    logic [31:0]          res;
`ifdef DOT8_SAT_EN
    logic                 sat_hit;
    logic                 sat_q;
`endif

    assign s1_adv       = !s1_valid_q || s1_go;
    assign accept       = bus.valid_in && s1_adv;
    assign bus.ready_in = s1_adv;

    // Form the four byte products; low 16 bits of the
    // sign-extended product equal the signed int8 x int8 result.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            p_d[k] = {{8{bus.a_in[8*k+7]}}, bus.a_in[8*k +: 8]}
                   * {{8{bus.b_in[8*k+7]}}, bus.b_in[8*k +: 8]};
        end
    end

    // Stage 1: capture products and tag of each accepted pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            for (int k = 0; k < 4; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.valid_in;
            end
            if (accept) begin
                p_q      <= p_d;
                s1_tag_q <= bus.tag_in;
            end
        end
    end

    // Reduce the products in 18 bits and widen (or clamp) to 32.
    always_comb begin
        sum = {{2{p_q[0][15]}}, p_q[0]}
            + {{2{p_q[1][15]}}, p_q[1]}
            + {{2{p_q[2][15]}}, p_q[2]}
            + {{2{p_q[3][15]}}, p_q[3]};
        res = {{14{sum[17]}}, sum};
`ifdef DOT8_SAT_EN
        sat_hit = 1'b0;
        if (sum > 18'sd32767) begin
            sat_hit = 1'b1;
            res     = 32'h0000_7FFF;
        end else if (sum < -18'sd32768) begin
            sat_hit = 1'b1;
            res     = 32'hFFFF_8000;
        end
`endif
    end

    if (OUT_REG) begin : g_out_reg
        logic                 s2_valid_q;
        logic [31:0]          s2_data_q;
        logic [TAG_WIDTH-1:0] s2_tag_q;
        logic                 s2_adv;

        assign s2_adv = !s2_valid_q || bus.ready_out;
        assign s1_go  = s2_adv;

        // Stage 2: register the reduced result; hold under stall.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_tag_q   <= '0;
            end else begin
                if (s2_adv) begin
                    s2_valid_q <= s1_valid_q;
                end
                if (s2_adv && s1_valid_q) begin
                    s2_data_q <= res;
                    s2_tag_q  <= s1_tag_q;
                end
            end
        end

        assign bus.valid_out = s2_valid_q;
        assign bus.data_out  = s2_data_q;
        assign bus.tag_out   = s2_tag_q;
    end else begin : g_out_comb
        assign s1_go         = bus.ready_out;
        assign bus.valid_out = s1_valid_q;
        assign bus.data_out  = res;
        assign bus.tag_out   = s1_tag_q;
    end

`ifdef DOT8_SAT_EN
    // Sticky flag: set when a clamped result leaves stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (s1_valid_q && s1_go && sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_vx_dot8_pe.sv
// tb_vx_dot8_pe: directed self-checking bench for vx_dot8_pe.
// Expectations follow DOT8_SAT_EN when that macro is defined.
module tb_vx_dot8_pe;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
`ifdef DOT8_SAT_EN
    logic sat_flag;
`endif

    vx_dot8_pe_if #(.TAG_WIDTH(4)) bus ();

    vx_dot8_pe #(
        .TAG_WIDTH(4),
        .OUT_REG  (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef DOT8_SAT_EN
        .sat_flag(sat_flag),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        bus.valid_in = v;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.tag_in   = t;
    endtask

    task automatic single(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t,
                          input logic [31:0] exp_d);
        drive(1'b1, a, b, t);
        step();
        drive(1'b0, '0, '0, '0);
        chk({name, "_lat1_valid"}, 32'(bus.valid_out), 32'd0);
        step();
        chk({name, "_lat2_valid"}, 32'(bus.valid_out), 32'd1);
        chk({name, "_data"}, bus.data_out, exp_d);
        chk({name, "_tag"}, 32'(bus.tag_out), 32'(t));
        step();
        chk({name, "_drain_valid"}, 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        int          tx;
        int          rx;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  prev_tag;

        reset = 1'b1;
        drive(1'b0, '0, '0, '0);
        bus.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", bus.data_out, 32'd0);
        chk("rst_tag_out", 32'(bus.tag_out), 32'd0);
        chk("rst_ready_in", 32'(bus.ready_in), 32'd1);
`ifdef DOT8_SAT_EN
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif

        single("basic", 32'h0403_0201, 32'h0101_0101, 4'd5, 32'h0000_000A);
        single("mixed", 32'hFF02_FE03, 32'h05FB_0A07, 4'd9, 32'hFFFF_FFF2);
`ifdef DOT8_SAT_EN
        chk("sat_flag_clear", 32'(sat_flag), 32'd0);
        single("neg_ext", 32'h8080_8080, 32'h8080_8080, 4'd1, 32'h0000_7FFF);
        chk("sat_flag_set", 32'(sat_flag), 32'd1);
        single("mix_ext", 32'h7F7F_7F7F, 32'h8080_8080, 4'd2, 32'hFFFF_8000);
`else
        single("neg_ext", 32'h8080_8080, 32'h8080_8080, 4'd1, 32'h0001_0000);
        single("mix_ext", 32'h7F7F_7F7F, 32'h8080_8080, 4'd2, 32'hFFFF_0200);
`endif

        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(1'b1, {4{8'(c + 1)}}, 32'h0102_0304, 4'(c));
            end else begin
                drive(1'b0, '0, '0, '0);
            end
            #1;
            if (c < 8) begin
                chk("stream_ready_in", 32'(bus.ready_in), 32'd1);
            end
            step();
            if (c >= 1 && c <= 8) begin
                chk("stream_valid", 32'(bus.valid_out), 32'd1);
                chk("stream_data", bus.data_out, 32'(c * 10));
                chk("stream_tag", 32'(bus.tag_out), 32'(c - 1));
            end else if (c == 9) begin
                chk("stream_drain", 32'(bus.valid_out), 32'd0);
            end
        end

        tx = 0;
        rx = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_tag = '0;
        for (int c = 0; c < 20 && rx < 6; c++) begin
            bus.ready_out = (c >= 4);
            if (tx < 6) begin
                drive(1'b1, {4{8'(tx + 1)}}, 32'h0101_0101, 4'(tx + 8));
            end else begin
                drive(1'b0, '0, '0, '0);
            end
            #1;
            if (tx < 6) begin
                chk("bp_ready_in", 32'(bus.ready_in), 32'(c < 2 || c >= 4));
            end
            if (prev_stall) begin
                chk("bp_hold_valid", 32'(bus.valid_out), 32'd1);
                chk("bp_hold_data", bus.data_out, prev_data);
                chk("bp_hold_tag", 32'(bus.tag_out), 32'(prev_tag));
            end
            if (bus.valid_out && bus.ready_out) begin
                chk("bp_data", bus.data_out, 32'(4 * (rx + 1)));
                chk("bp_tag", 32'(bus.tag_out), 32'(rx + 8));
                rx++;
            end
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_data = bus.data_out;
            prev_tag = bus.tag_out;
            if (bus.valid_in && bus.ready_in) begin
                tx++;
            end
            step();
        end
        bus.ready_out = 1'b1;
        drive(1'b0, '0, '0, '0);
        chk("bp_accepted", 32'(tx), 32'd6);
        chk("bp_retired", 32'(rx), 32'd6);
        step();
        chk("bp_no_dup", 32'(bus.valid_out), 32'd0);

        drive(1'b1, 32'h0403_0201, 32'h0101_0101, 4'd3);
        step();
        drive(1'b1, 32'h7F7F_7F7F, 32'h8080_8080, 4'd4);
        step();
        drive(1'b0, '0, '0, '0);
        chk("rst_mid_pre_valid", 32'(bus.valid_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_mid_data", bus.data_out, 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rst_mid_no_stale", 32'(bus.valid_out), 32'd0);
        end
        chk("rst_mid_ready_in", 32'(bus.ready_in), 32'd1);
`ifdef DOT8_SAT_EN
        chk("rst_mid_sat_flag", 32'(sat_flag), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
